// File: rtl/mips_mc_controller_pkg.sv
// Shared types, opcode constants and opcode-class helpers for the multicycle MIPS controller.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        IEXEC   = 4'd9,
        IWB     = 4'd10,
        JUMP    = 4'd11,
        JR      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLEZ  = 6'b000110;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_FUNCT = 3'b010,
        ALU_OR    = 3'b011,
        ALU_AND   = 3'b100,
        ALU_XOR   = 3'b101,
        ALU_SLT   = 3'b110,
        ALU_LUI   = 3'b111
    } aluop_t;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       ne;
        logic       irwrite;
        logic       iord;
        logic       memwrite;
        logic [1:0] memsize;
        logic       lbu;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       link;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       zext;
        aluop_t     aluop;
        logic [1:0] pcsrc;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    function automatic logic is_load(input logic [5:0] op);
        return op inside {OP_LW, OP_LH, OP_LB, OP_LBU};
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return op inside {OP_SW, OP_SH, OP_SB};
    endfunction

    function automatic logic is_branch(input logic [5:0] op);
        return op inside {OP_BEQ, OP_BNE, OP_BLEZ};
    endfunction

    function automatic logic is_imm(input logic [5:0] op);
        return op inside {OP_ADDI, OP_ORI, OP_ANDI, OP_XORI, OP_SLTI, OP_LUI};
    endfunction

    function automatic logic is_jump(input logic [5:0] op);
        return op inside {OP_J, OP_JAL};
    endfunction

    function automatic logic op_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || is_load(op) || is_store(op) || is_branch(op)
               || is_imm(op) || is_jump(op);
    endfunction

    function automatic logic [1:0] mem_size(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW: return SIZE_WORD;
            OP_LH, OP_SH: return SIZE_HALF;
            default:      return SIZE_BYTE;
        endcase
    endfunction

    function automatic aluop_t imm_aluop(input logic [5:0] op);
        case (op)
            OP_ORI:  return ALU_OR;
            OP_ANDI: return ALU_AND;
            OP_XORI: return ALU_XOR;
            OP_SLTI: return ALU_SLT;
            OP_LUI:  return ALU_LUI;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic imm_zext(input logic [5:0] op);
        return op inside {OP_ORI, OP_ANDI, OP_XORI};
    endfunction

endpackage

// File: rtl/mips_mc_controller_if.sv
// Controller <-> datapath bundle: IR fields and memory handshake in, control strobes and selects out.
interface mips_mc_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       mem_ready;
    logic       pcwrite;
    logic       branch;
    logic       ne;
    logic       irwrite;
    logic       iord;
    logic       memwrite;
    logic [1:0] memsize;
    logic       lbu;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       link;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zext;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  op, funct, mem_ready,
        output pcwrite, branch, ne, irwrite, iord, memwrite, memsize, lbu, regwrite, regdst,
               memtoreg, link, alusrca, alusrcb, zext, aluop, pcsrc, instr_done, illegal
    );

    modport slave (
        output op, funct, mem_ready,
        input  pcwrite, branch, ne, irwrite, iord, memwrite, memsize, lbu, regwrite, regdst,
               memtoreg, link, alusrca, alusrcb, zext, aluop, pcsrc, instr_done, illegal
    );
endinterface

// File: rtl/mips_mc_controller_outdec.sv
// Combinational Moore decode of controller state (plus op and memory-ready) into the control vector.
module mc_ctrl_outdec
    import mips_mc_pkg::*;
(
    input  state_t     state_i,
    input  logic [5:0] op_i,
    input  logic       rdy_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            FETCH: begin
                ctrl_o.alusrcb = SRCB_FOUR;
                ctrl_o.aluop   = ALU_ADD;
                ctrl_o.pcsrc   = PC_ALU;
                ctrl_o.irwrite = rdy_i;
                ctrl_o.pcwrite = rdy_i;
            end
            DECODE: begin
                ctrl_o.alusrcb = SRCB_IMMSH;
                ctrl_o.aluop   = ALU_ADD;
                ctrl_o.illegal = !op_legal(op_i);
            end
            MEMADR: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_IMM;
                ctrl_o.aluop   = ALU_ADD;
            end
            MEMRD: begin
                ctrl_o.iord    = 1'b1;
                ctrl_o.memsize = mem_size(op_i);
                ctrl_o.lbu     = (op_i == OP_LBU);
            end
            MEMWB: begin
                ctrl_o.memtoreg   = 1'b1;
                ctrl_o.regwrite   = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            MEMWR: begin
                // Strobe is held through wait states; completion marks the final cycle
                ctrl_o.iord       = 1'b1;
                ctrl_o.memwrite   = 1'b1;
                ctrl_o.memsize    = mem_size(op_i);
                ctrl_o.instr_done = rdy_i;
            end
            EXECUTE: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_RT;
                ctrl_o.aluop   = ALU_FUNCT;
            end
            ALUWB: begin
                ctrl_o.regdst     = 1'b1;
                ctrl_o.regwrite   = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            BRANCH: begin
                ctrl_o.alusrca    = 1'b1;
                ctrl_o.alusrcb    = SRCB_RT;
                ctrl_o.aluop      = (op_i == OP_BLEZ) ? ALU_SLT : ALU_SUB;
                ctrl_o.pcsrc      = PC_ALUOUT;
                ctrl_o.branch     = 1'b1;
                ctrl_o.ne         = (op_i == OP_BNE);
                ctrl_o.instr_done = 1'b1;
            end
            IEXEC: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_IMM;
                ctrl_o.aluop   = imm_aluop(op_i);
                ctrl_o.zext    = imm_zext(op_i);
            end
            IWB: begin
                ctrl_o.regwrite   = 1'b1;
                ctrl_o.zext       = imm_zext(op_i);
                ctrl_o.instr_done = 1'b1;
            end
            JUMP: begin
                ctrl_o.pcsrc      = PC_JUMP;
                ctrl_o.pcwrite    = 1'b1;
                ctrl_o.regwrite   = (op_i == OP_JAL);
                ctrl_o.link       = (op_i == OP_JAL);
                ctrl_o.instr_done = 1'b1;
            end
            JR: begin
                ctrl_o.pcsrc      = PC_RS;
                ctrl_o.pcwrite    = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM: state register, next-state logic and reset-gated control outputs.
// Optional MC_MEM_WAIT_EN: honour mem_ready wait states; otherwise memory states last one cycle.
module mips_mc_controller
    import mips_mc_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input logic                   clk,
    input logic                   reset,
    mips_mc_controller_if.master  bus
);

    state_t state_q, state_d;
    logic   rdy;
    ctrl_t  dec_ctrl;
    ctrl_t  out_ctrl;

`ifdef MC_MEM_WAIT_EN
    assign rdy = bus.mem_ready;
`else
    assign rdy = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (rdy) state_d = DECODE;
            DECODE: begin
                if (is_load(bus.op) || is_store(bus.op)) state_d = MEMADR;
                else if (bus.op == OP_RTYPE)             state_d = (bus.funct == FUNCT_JR) ? JR : EXECUTE;
                else if (is_branch(bus.op))              state_d = BRANCH;
                else if (is_imm(bus.op))                 state_d = IEXEC;
                else if (is_jump(bus.op))                state_d = JUMP;
                else                                     state_d = FETCH;
            end
            MEMADR:  state_d = is_store(bus.op) ? MEMWR : MEMRD;
            MEMRD:   if (rdy) state_d = MEMWB;
            MEMWR:   if (rdy) state_d = FETCH;
            EXECUTE: state_d = ALUWB;
            IEXEC:   state_d = IWB;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= state_t'(RESET_STATE);
        else        state_q <= state_d;
    end

    mc_ctrl_outdec u_outdec (
        .state_i (state_q),
        .op_i    (bus.op),
        .rdy_i   (rdy),
        .ctrl_o  (dec_ctrl)
    );

    // Gating by the raw reset input suppresses strobes in the cycle reset is seen
    assign out_ctrl = reset ? dec_ctrl : '0;

    assign bus.pcwrite    = out_ctrl.pcwrite;
    assign bus.branch     = out_ctrl.branch;
    assign bus.ne         = out_ctrl.ne;
    assign bus.irwrite    = out_ctrl.irwrite;
    assign bus.iord       = out_ctrl.iord;
    assign bus.memwrite   = out_ctrl.memwrite;
    assign bus.memsize    = out_ctrl.memsize;
    assign bus.lbu        = out_ctrl.lbu;
    assign bus.regwrite   = out_ctrl.regwrite;
    assign bus.regdst     = out_ctrl.regdst;
    assign bus.memtoreg   = out_ctrl.memtoreg;
    assign bus.link       = out_ctrl.link;
    assign bus.alusrca    = out_ctrl.alusrca;
    assign bus.alusrcb    = out_ctrl.alusrcb;
    assign bus.zext       = out_ctrl.zext;
    assign bus.aluop      = out_ctrl.aluop;
    assign bus.pcsrc      = out_ctrl.pcsrc;
    assign bus.instr_done = out_ctrl.instr_done;
    assign bus.illegal    = out_ctrl.illegal;

endmodule
